// File: rtl/axis_fifo_if.sv
// AXI-Stream FIFO bus bundle: write stream, read stream and fill status.
// slave is the FIFO's view, master is the surrounding logic's view.
interface axis_fifo_if #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 9
);

  logic [DATA_WIDTH-1:0] s_tdata;
  logic                  s_tlast;
  logic                  s_tvalid;
  logic                  s_tready;

  logic [DATA_WIDTH-1:0] m_tdata;
  logic                  m_tlast;
  logic                  m_tvalid;
  logic                  m_tready;

  logic [ADDR_WIDTH:0]   level;
  logic                  almost_full;
  logic                  almost_empty;
  logic                  full;
  logic                  empty;

  modport slave (
    input  s_tdata,
    input  s_tlast,
    input  s_tvalid,
    output s_tready,
    output m_tdata,
    output m_tlast,
    output m_tvalid,
    input  m_tready,
    output level,
    output almost_full,
    output almost_empty,
    output full,
    output empty
  );

  modport master (
    output s_tdata,
    output s_tlast,
    output s_tvalid,
    input  s_tready,
    input  m_tdata,
    input  m_tlast,
    input  m_tvalid,
    output m_tready,
    input  level,
    input  almost_full,
    input  almost_empty,
    input  full,
    input  empty
  );

endinterface

// File: rtl/axis_fifo.sv
// FWFT AXI-Stream FIFO on a simple-dual-port RAM with a 2-entry output stage.
// AXIS_FIFO_PACKET_EN selects store-and-forward; default is cut-through.
module axis_fifo #(
  parameter int DATA_WIDTH          = 128,
  parameter int ADDR_WIDTH          = 9,
  parameter int DEPTH               = 512,
  parameter int ALMOST_FULL_THRESH  = DEPTH - 4,
  parameter int ALMOST_EMPTY_THRESH = 4
) (
  input logic        clk,
  input logic        reset_n,
  axis_fifo_if.slave bus
);

  localparam int LW = ADDR_WIDTH + 1;
  localparam int WW = DATA_WIDTH + 1;

  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_AF   = LW'(ALMOST_FULL_THRESH);
  localparam logic [LW-1:0] LVL_AE   = LW'(ALMOST_EMPTY_THRESH);

  localparam logic [ADDR_WIDTH-1:0] PTR_LAST = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

  logic [WW-1:0] mem [DEPTH];
  logic [WW-1:0] ram_dout;

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic [LW-1:0]         ram_cnt_q, ram_cnt_d;
  logic                  infl_q, infl_d;

  logic [WW-1:0] head_q, head_d;
  logic          head_v_q, head_v_d;
  logic [WW-1:0] skid_q, skid_d;
  logic          skid_v_q, skid_v_d;

  logic s_tready_q, s_tready_d;
  logic full_q, full_d;
  logic empty_q, empty_d;
  logic af_q, af_d;
  logic ae_q, ae_d;

  logic       wr_en;
  logic       rd_xfer;
  logic       rd_issue;
  logic       pkt_ok;
  logic [1:0] occ;

  always_comb begin
    wr_en   = bus.s_tvalid & s_tready_q;
    rd_xfer = head_v_q & bus.m_tready;
    // output-stage words one edge from now
    occ = {1'b0, head_v_q} + {1'b0, skid_v_q}
        + {1'b0, infl_q} - {1'b0, rd_xfer};
    rd_issue = (ram_cnt_q != '0)
             & (occ < 2'd2)
             & pkt_ok;
  end

`ifdef AXIS_FIFO_PACKET_EN
  logic          tlast_mem [DEPTH];
  logic [LW-1:0] pkt_cnt_q, pkt_cnt_d;
  logic          pkt_inc;
  logic          pkt_dec;

  always_comb begin
    pkt_inc   = wr_en & bus.s_tlast;
    pkt_dec   = rd_issue & tlast_mem[rd_ptr_q];
    pkt_cnt_d = pkt_cnt_q + LW'(pkt_inc)
              - LW'(pkt_dec);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pkt_cnt_q <= '0;
    end else begin
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

  // tlast shadow, read combinationally to count packets on issue
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tlast_mem[wr_ptr_q] <= bus.s_tlast;
    end
  end

  // full releases an oversized packet that would otherwise deadlock
  assign pkt_ok = (pkt_cnt_q != '0) | full_q;
`else
  assign pkt_ok = 1'b1;
`endif

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    if (wr_en) begin
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0
               : wr_ptr_q + PTR_ONE;
    end
    rd_ptr_d = rd_ptr_q;
    if (rd_issue) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0
               : rd_ptr_q + PTR_ONE;
    end
    infl_d    = rd_issue;
    ram_cnt_d = ram_cnt_q + LW'(wr_en)
              - LW'(rd_issue);
  end

  always_comb begin
    head_d   = head_q;
    head_v_d = head_v_q;
    skid_d   = skid_q;
    skid_v_d = skid_v_q;
    if (rd_xfer) begin
      if (skid_v_q) begin
        head_d   = skid_q;
        skid_v_d = infl_q;
        if (infl_q) begin
          skid_d = ram_dout;
        end
      end else begin
        head_v_d = infl_q;
        if (infl_q) begin
          head_d = ram_dout;
        end
      end
    end else if (infl_q) begin
      if (!head_v_q) begin
        head_d   = ram_dout;
        head_v_d = 1'b1;
      end else begin
        skid_d   = ram_dout;
        skid_v_d = 1'b1;
      end
    end
  end

  always_comb begin
    level_d    = level_q + LW'(wr_en)
               - LW'(rd_xfer);
    full_d     = (level_d == LVL_FULL);
    empty_d    = (level_d == '0);
    af_d       = (level_d >= LVL_AF);
    ae_d       = (level_d <= LVL_AE);
    s_tready_d = ~full_d;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= {bus.s_tlast, bus.s_tdata};
    end
    if (rd_issue) begin
      ram_dout <= mem[rd_ptr_q];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      ram_cnt_q  <= '0;
      infl_q     <= 1'b0;
      head_q     <= '0;
      head_v_q   <= 1'b0;
      skid_q     <= '0;
      skid_v_q   <= 1'b0;
      s_tready_q <= 1'b0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      af_q       <= 1'b0;
      ae_q       <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      ram_cnt_q  <= ram_cnt_d;
      infl_q     <= infl_d;
      head_q     <= head_d;
      head_v_q   <= head_v_d;
      skid_q     <= skid_d;
      skid_v_q   <= skid_v_d;
      s_tready_q <= s_tready_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      af_q       <= af_d;
      ae_q       <= ae_d;
    end
  end

  assign bus.s_tready     = s_tready_q;
  assign bus.m_tdata      = head_q[DATA_WIDTH-1:0];
  assign bus.m_tlast      = head_q[DATA_WIDTH];
  assign bus.m_tvalid     = head_v_q;
  assign bus.level        = level_q;
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = af_q;
  assign bus.almost_empty = ae_q;

endmodule

// File: tb/tb_axis_fifo.sv
// Directed bench for axis_fifo: reset, latency, fill/wrap, streaming,
// packet mode (when AXIS_FIFO_PACKET_EN is defined) and async reset.
module tb_axis_fifo;

  localparam int DW    = 32;
  localparam int AW    = 3;
  localparam int DEPTH = 5;
  localparam int AFT   = 4;
  localparam int AET   = 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  axis_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();

  axis_fifo #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .DEPTH(DEPTH),
    .ALMOST_FULL_THRESH(AFT),
    .ALMOST_EMPTY_THRESH(AET)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  logic [DW:0] sb [$];
  logic [DW:0] ew;
  logic        acc_w, acc_r, st_prev;
  logic [DW-1:0] d_prev;
  int wr_cnt, rd_cnt, wr_nx, rd_nx, lvl;
  int steady, miss_w, miss_r;

  initial begin
    bus.s_tdata  = '0;
    bus.s_tlast  = 1'b0;
    bus.s_tvalid = 1'b0;
    bus.m_tready = 1'b0;

    // reset and idle
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_tready", 64'(bus.s_tready), 64'd0);
    chk("rst_m_tvalid", 64'(bus.m_tvalid), 64'd0);
    chk("rst_empty", 64'(bus.empty), 64'd1);
    chk("rst_level", 64'(bus.level), 64'd0);
    reset_n = 1'b1;
    tick();
    chk("idle_s_tready", 64'(bus.s_tready), 64'd1);
    chk("idle_empty", 64'(bus.empty), 64'd1);
    chk("idle_level", 64'(bus.level), 64'd0);
    chk("idle_ae", 64'(bus.almost_empty), 64'd1);

    // first-word latency
    bus.m_tready = 1'b1;
    bus.s_tdata  = 32'hA5;
    bus.s_tlast  = 1'b1;
    bus.s_tvalid = 1'b1;
    tick();
    bus.s_tvalid = 1'b0;
    chk("lat_lvl_n", 64'(bus.level), 64'd1);
    chk("lat_vld_n", 64'(bus.m_tvalid), 64'd0);
    tick();
    chk("lat_vld_n1", 64'(bus.m_tvalid), 64'd0);
    tick();
    chk("lat_vld_n2", 64'(bus.m_tvalid), 64'd1);
    chk("lat_data", 64'(bus.m_tdata), 64'hA5);
    chk("lat_last", 64'(bus.m_tlast), 64'd1);
    tick();
    chk("lat_lvl_end", 64'(bus.level), 64'd0);
    chk("lat_vld_end", 64'(bus.m_tvalid), 64'd0);
    chk("lat_empty", 64'(bus.empty), 64'd1);

    // fill 1..5 with the reader stalled
    bus.m_tready = 1'b0;
    bus.s_tlast  = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      bus.s_tdata  = DW'(k);
      bus.s_tvalid = 1'b1;
      tick();
      chk("fill_level", 64'(bus.level), 64'(k));
      chk("fill_af", 64'(bus.almost_full),
          64'(k >= 4));
      chk("fill_full", 64'(bus.full), 64'(k == 5));
      chk("fill_rdy", 64'(bus.s_tready),
          64'(k != 5));
    end
    chk("fill_head_v", 64'(bus.m_tvalid), 64'd1);
    chk("fill_head_d", 64'(bus.m_tdata), 64'd1);
    chk("fill_ae", 64'(bus.almost_empty), 64'd0);

    // read 1..8 while writing 6..8 through the wrap
    bus.s_tdata  = 32'd6;
    bus.m_tready = 1'b1;
    wr_nx = 6;
    rd_nx = 1;
    lvl   = 5;
    for (int c = 0; c < 40 && rd_nx <= 8; c++) begin
      acc_w = bus.s_tvalid && bus.s_tready;
      acc_r = bus.m_tvalid && bus.m_tready;
      if (acc_r) begin
        chk("wrap_data", 64'(bus.m_tdata), 64'(rd_nx));
        rd_nx++;
      end
      tick();
      lvl = lvl + int'(acc_w) - int'(acc_r);
      if (acc_w) begin
        wr_nx++;
        if (wr_nx <= 8) bus.s_tdata = DW'(wr_nx);
        else bus.s_tvalid = 1'b0;
      end
      chk("wrap_level", 64'(bus.level), 64'(lvl));
      chk("wrap_max", 64'(bus.level <= 5), 64'd1);
    end
    chk("wrap_count", 64'(rd_nx), 64'd9);
    chk("wrap_empty", 64'(bus.empty), 64'd1);

    // 1000 words: random handshakes, then both held high
    sb.delete();
    wr_cnt  = 0;
    rd_cnt  = 0;
    steady  = 0;
    miss_w  = 0;
    miss_r  = 0;
    for (int c = 0; c < 20000 && rd_cnt < 1000; c++) begin
      if (wr_cnt >= 700) steady++;
      bus.s_tvalid = (wr_cnt < 1000) &&
        (steady > 0 || $urandom_range(0, 1) == 1);
      bus.s_tdata = DW'($urandom);
      bus.s_tlast = (steady > 0) || (wr_cnt == 999) ||
        ($urandom_range(0, 3) == 0);
      bus.m_tready = (steady > 0) ||
        ($urandom_range(0, 1) == 1);
      acc_w = bus.s_tvalid && bus.s_tready;
      acc_r = bus.m_tvalid && bus.m_tready;
      if (acc_r) begin
        if (sb.size() == 0) begin
          chk("stream_extra", 64'd1, 64'd0);
        end else begin
          ew = sb.pop_front();
          chk("stream_data", 64'(bus.m_tdata),
              64'(ew[DW-1:0]));
          chk("stream_last", 64'(bus.m_tlast),
              64'(ew[DW]));
        end
        rd_cnt++;
      end
      if (acc_w) begin
        sb.push_back({bus.s_tlast, bus.s_tdata});
        wr_cnt++;
      end
      if (steady > 10 && wr_cnt < 1000 && !acc_w)
        miss_w++;
      if (steady > 10 && !acc_r) miss_r++;
      st_prev = bus.m_tvalid && !bus.m_tready;
      d_prev  = bus.m_tdata;
      tick();
      if (st_prev) begin
        chk("stall_valid", 64'(bus.m_tvalid), 64'd1);
        chk("stall_data", 64'(bus.m_tdata),
            64'(d_prev));
      end
    end
    bus.s_tvalid = 1'b0;
    chk("stream_count", 64'(rd_cnt), 64'd1000);
    chk("stream_left", 64'(sb.size()), 64'd0);
    chk("stream_wr_rate", 64'(miss_w), 64'd0);
    chk("stream_rd_rate", 64'(miss_r), 64'd0);
    tick();
    chk("stream_empty", 64'(bus.empty), 64'd1);

`ifdef AXIS_FIFO_PACKET_EN
    // 3-word packet held until its tlast is in
    bus.m_tready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.s_tdata  = DW'(10 + k);
      bus.s_tlast  = (k == 2);
      bus.s_tvalid = 1'b1;
      tick();
      chk("pkt_hold", 64'(bus.m_tvalid), 64'd0);
    end
    bus.s_tvalid = 1'b0;
    tick();
    chk("pkt_n1", 64'(bus.m_tvalid), 64'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("pkt_beat_v", 64'(bus.m_tvalid), 64'd1);
      chk("pkt_beat_d", 64'(bus.m_tdata),
          64'(10 + k));
      chk("pkt_beat_l", 64'(bus.m_tlast),
          64'(k == 2));
    end
    tick();
    chk("pkt_done", 64'(bus.m_tvalid), 64'd0);

    // oversized packet: released by full
    for (int k = 0; k < 5; k++) begin
      bus.s_tdata  = DW'(20 + k);
      bus.s_tlast  = 1'b0;
      bus.s_tvalid = 1'b1;
      tick();
      chk("big_hold", 64'(bus.m_tvalid), 64'd0);
    end
    chk("big_full", 64'(bus.full), 64'd1);
    bus.s_tdata = 32'd25;
    bus.s_tlast = 1'b1;
    rd_nx = 20;
    for (int c = 0; c < 30 && rd_nx <= 25; c++) begin
      acc_w = bus.s_tvalid && bus.s_tready;
      acc_r = bus.m_tvalid && bus.m_tready;
      if (acc_r) begin
        chk("big_data", 64'(bus.m_tdata), 64'(rd_nx));
        chk("big_last", 64'(bus.m_tlast),
            64'(rd_nx == 25));
        rd_nx++;
      end
      tick();
      if (acc_w) bus.s_tvalid = 1'b0;
    end
    chk("big_count", 64'(rd_nx), 64'd26);
    chk("big_empty", 64'(bus.empty), 64'd1);
`endif

    // asynchronous reset while full
    bus.m_tready = 1'b0;
    bus.s_tlast  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      bus.s_tdata  = DW'(40 + k);
      bus.s_tvalid = 1'b1;
      tick();
    end
    bus.s_tvalid = 1'b0;
    chk("ar_pre_level", 64'(bus.level), 64'd5);
    chk("ar_pre_valid", 64'(bus.m_tvalid), 64'd1);
    #3;
    reset_n = 1'b0;
    #1;
    chk("ar_s_tready", 64'(bus.s_tready), 64'd0);
    chk("ar_m_tvalid", 64'(bus.m_tvalid), 64'd0);
    chk("ar_m_tdata", 64'(bus.m_tdata), 64'd0);
    chk("ar_m_tlast", 64'(bus.m_tlast), 64'd0);
    chk("ar_level", 64'(bus.level), 64'd0);
    chk("ar_full", 64'(bus.full), 64'd0);
    chk("ar_empty", 64'(bus.empty), 64'd1);
    chk("ar_af", 64'(bus.almost_full), 64'd0);
    chk("ar_ae", 64'(bus.almost_empty), 64'd1);
    tick();
    reset_n = 1'b1;
    tick();
    chk("ar_rdy_back", 64'(bus.s_tready), 64'd1);
    chk("ar_lvl_back", 64'(bus.level), 64'd0);
    bus.m_tready = 1'b1;
    bus.s_tdata  = 32'h77;
    bus.s_tvalid = 1'b1;
    tick();
    bus.s_tvalid = 1'b0;
    chk("ar_new_lvl", 64'(bus.level), 64'd1);
    tick();
    tick();
    chk("ar_new_v", 64'(bus.m_tvalid), 64'd1);
    chk("ar_new_d", 64'(bus.m_tdata), 64'h77);
    tick();
    chk("ar_new_end", 64'(bus.level), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
